// File: rtl/switch_status_pkg.sv
// Shared constants for the board switch reader: default timing parameters
// and the width of the per-bit stability counter.
package switch_status_pkg;

  localparam int DEF_NUM_IN       = 8;
  localparam int DEF_TICK_DIV     = 50000;
  localparam int DEF_STABLE_TICKS = 4;
  localparam int DEF_ACT_W        = 22;

  // Stability counter is wide enough for STABLE_TICKS up to 15.
  localparam int STAB_CNT_W = 4;

  // Counter value at which a persistent difference is accepted as the new level.
  function automatic logic [STAB_CNT_W-1:0] stab_limit(input int stable_ticks);
    return STAB_CNT_W'(stable_ticks - 1);
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// One board input: two-flop synchroniser, tick-paced stability counter,
// debounced level and single-cycle rise/fall strobes.
module sw_debounce
  import switch_status_pkg::*;
#(
  parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic clk,
  input  logic rstn,
  input  logic pin,
  input  logic tick,
  output logic level,
  output logic rise,
  output logic fall
);

  logic                  sync1;
  logic                  sync2;
  logic                  level_d;
  logic [STAB_CNT_W-1:0] cnt;

  // Bring the asynchronous pin into the clk domain.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after it has differed on enough consecutive ticks.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (tick) begin
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == stab_limit(STABLE_TICKS)) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + STAB_CNT_W'(1);
      end
    end
  end

  // Edge strobes appear the cycle after the level flips and last one cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      level_d <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      level_d <= level;
      rise    <= level & ~level_d;
      fall    <= ~level & level_d;
    end
  end

endmodule

// File: rtl/switch_status.sv
// Board input reader: polarity, debounce per bit, sticky change bits with a
// maskable interrupt and a stretched activity indicator.
module switch_status
  import switch_status_pkg::*;
#(
  parameter int NUM_IN       = DEF_NUM_IN,
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int ACT_W        = DEF_ACT_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              invert,
  input  logic [NUM_IN-1:0] sw_raw,
  output logic [NUM_IN-1:0] sw_level,
  output logic [NUM_IN-1:0] sw_rise,
  output logic [NUM_IN-1:0] sw_fall,
  output logic [NUM_IN-1:0] chg_sticky,
  input  logic              clr_strobe,
  input  logic [NUM_IN-1:0] clr_mask,
  input  logic [NUM_IN-1:0] irq_en,
  output logic              irq,
  output logic              act
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PRE_W-1:0]  pre_cnt;
  logic              tick;
  logic [NUM_IN-1:0] pin;
  logic [NUM_IN-1:0] edge_any;
  logic [NUM_IN-1:0] clr_bits;
  logic [ACT_W-1:0]  act_cnt;

  // Toggling invert flips every bit and is debounced like any pin change.
  assign pin      = invert ? ~sw_raw : sw_raw;
  assign tick     = (pre_cnt == PRE_W'(TICK_DIV - 1));
  assign edge_any = sw_rise | sw_fall;
  assign clr_bits = clr_strobe ? clr_mask : '0;

  // Free-running prescaler producing the debounce sample tick.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pre_cnt <= '0;
    end else if (tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_IN; g++) begin : g_bit
      sw_debounce #(
        .STABLE_TICKS(STABLE_TICKS)
      ) u_deb (
        .clk  (clk),
        .rstn (rstn),
        .pin  (pin[g]),
        .tick (tick),
        .level(sw_level[g]),
        .rise (sw_rise[g]),
        .fall (sw_fall[g])
      );
    end
  endgenerate

  // Sticky change bits; a new edge beats a simultaneous host clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      chg_sticky <= '0;
    end else begin
      chg_sticky <= (chg_sticky & ~clr_bits) | edge_any;
    end
  end

  // Level interrupt from any enabled sticky bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      irq <= 1'b0;
    end else begin
      irq <= |(chg_sticky & irq_en);
    end
  end

  // Activity stretch: any edge reloads the down counter, which stops at zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      act_cnt <= '0;
      act     <= 1'b0;
    end else begin
      if (|edge_any) begin
        act_cnt <= '1;
      end else if (act_cnt != '0) begin
        act_cnt <= act_cnt - ACT_W'(1);
      end
      act <= (act_cnt != '0);
    end
  end

endmodule
